// File: rtl/sv_fixed_pkg.sv
// ============================================================================
//  Module      : sv_fixed_pkg
//  Description : Shared constants, slice offsets, FSM encoding and helpers for
//                the signed vector / scalar divider.
//                Optional macro SV_DIV_ROUND_EN adds one guard quotient bit so
//                the result can be rounded half-up instead of truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sv_fixed_pkg;

    localparam int FRAC_BITS = 10;
    localparam int INT_BITS  = 8;
    localparam int MAG_W     = INT_BITS + FRAC_BITS;   // 18
    localparam int COMP_W    = 1 + MAG_W;              // 19
    localparam int VEC_W     = 3 * COMP_W;             // 57

    localparam logic [MAG_W-1:0] MAG_MAX = 18'h3FFFF;

    // Component slice offsets inside the packed vector {x, y, z}
    localparam int X_LSB = 2 * COMP_W;
    localparam int Y_LSB = COMP_W;
    localparam int Z_LSB = 0;

`ifdef SV_DIV_ROUND_EN
    localparam int GUARD_BITS = 1;
`else
    localparam int GUARD_BITS = 0;
`endif

    // Numerator is {magnitude, FRAC_BITS (+guard) zeros}; one quotient bit
    // per numerator bit, so the iteration count equals the numerator width.
    localparam int DIV_ITERS = MAG_W + FRAC_BITS + GUARD_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ITER  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Low bit position of component c (0 = x, 1 = y, 2 = z)
    function automatic logic [5:0] comp_lsb(input logic [1:0] c);
        case (c)
            2'd0:    return 6'(X_LSB);
            2'd1:    return 6'(Y_LSB);
            default: return 6'(Z_LSB);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/signed_vector_scalar_divider_if.sv
// ============================================================================
//  Module      : signed_vector_scalar_divider_if
//  Description : Input and output valid/ready channels of the divider.
//                master : producer/consumer side (drives in_*, out_ready)
//                slave  : divider side (drives in_ready, out_*, div_by_zero)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface signed_vector_scalar_divider_if;
    import sv_fixed_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [VEC_W-1:0]  in_vector;
    logic [COMP_W-1:0] in_scalar;
    logic              out_valid;
    logic              out_ready;
    logic [VEC_W-1:0]  out_vector;
    logic              div_by_zero;

    modport master (
        output in_valid, in_vector, in_scalar, out_ready,
        input  in_ready, out_valid, out_vector, div_by_zero
    );

    modport slave (
        input  in_valid, in_vector, in_scalar, out_ready,
        output in_ready, out_valid, out_vector, div_by_zero
    );

endinterface

`default_nettype wire

// File: rtl/sv_div_core.sv
// ============================================================================
//  Module      : sv_div_core
//  Description : Unsigned radix-2 restoring divider, one quotient bit per
//                cycle, MSB first. The quotient is shifted into the numerator
//                register as numerator bits are consumed.
//  Ports       : clk, rst        - clock, async active-high reset
//                start_i         - load operands (ignored divisor==0 check is
//                                  the caller's job)
//                dividend_i      - ITERS-bit numerator
//                divisor_i       - DEN_W-bit nonzero divisor
//                busy_o          - iterations in progress
//                last_o          - final iteration happens on this edge
//                quotient_o      - quotient, valid after last_o
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sv_div_core
    import sv_fixed_pkg::*;
#(
    parameter int ITERS = DIV_ITERS,
    parameter int DEN_W = MAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [ITERS-1:0] dividend_i,
    input  logic [DEN_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             last_o,
    output logic [ITERS-1:0] quotient_o
);

    localparam int CNT_W = $clog2(ITERS);

    logic             busy_q;
    logic [CNT_W-1:0] iter_q;
    logic [DEN_W-1:0] rem_q;
    logic [DEN_W-1:0] den_q;
    logic [ITERS-1:0] quo_q;

    logic [DEN_W:0]   w_shifted;
    logic [DEN_W+1:0] w_trial;
    logic             w_qbit;
    logic [DEN_W-1:0] w_rem_next;
    logic             w_unused_trial;

    // The remainder is always below the divisor, so after the shift it is
    // below 2*divisor and the reduced remainder fits back in DEN_W bits.
    assign w_shifted      = {rem_q, quo_q[ITERS-1]};
    assign w_trial        = {1'b0, w_shifted} - {2'b00, den_q};
    assign w_qbit         = ~w_trial[DEN_W+1];
    assign w_rem_next     = w_qbit ? w_trial[DEN_W-1:0] : w_shifted[DEN_W-1:0];
    assign w_unused_trial = w_trial[DEN_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            iter_q <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            iter_q <= CNT_W'(ITERS - 1);
            rem_q  <= '0;
            den_q  <= divisor_i;
            quo_q  <= dividend_i;
        end else if (busy_q) begin
            rem_q  <= w_rem_next;
            quo_q  <= {quo_q[ITERS-2:0], w_qbit};
            iter_q <= iter_q - 1'b1;
            if (iter_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o     = busy_q;
    assign last_o     = busy_q && (iter_q == '0);
    assign quotient_o = quo_q;

endmodule

`default_nettype wire

// File: rtl/signed_vector_scalar_divider.sv
// ============================================================================
//  Module      : signed_vector_scalar_divider
//  Description : Divides each 19-bit sign-magnitude component (s.8.10) of a
//                packed {x, y, z} vector by one sign-magnitude scalar, using
//                one time-shared restoring divider. Handles sign, saturation,
//                divide-by-zero and the valid/ready handshakes.
//                Optional macro SV_DIV_ROUND_EN: round half-up via one guard
//                quotient bit (one extra iteration per component).
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - slave side of signed_vector_scalar_divider_if
//                       (in_valid/in_ready/in_vector/in_scalar,
//                        out_valid/out_ready/out_vector/div_by_zero)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_vector_scalar_divider
    import sv_fixed_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    signed_vector_scalar_divider_if.slave bus
);

    state_t             state_q, state_d;
    logic [1:0]         comp_q, comp_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [COMP_W-1:0]  scal_q, scal_d;
    logic [VEC_W-1:0]   res_q, res_d;

    logic               w_core_start;
    logic               w_core_busy;
    logic               w_core_last;
    logic [DIV_ITERS-1:0] w_quo;

    logic [5:0]         w_lsb;
    logic [COMP_W-1:0]  w_dividend;
    logic [MAG_W-1:0]   w_div_mag;
    logic               w_dz;
    logic [DIV_ITERS-1:0] w_num;
    logic [DIV_ITERS-1:0] w_q_full;
    logic               w_sat;
    logic [MAG_W-1:0]   w_mag_res;
    logic               w_sign_res;
    logic [COMP_W-1:0]  w_comp_res;
    logic               w_unused_busy;

    // ------------------------------------------------------------------
    // Current component operands
    // ------------------------------------------------------------------
    assign w_lsb      = comp_lsb(comp_q);
    assign w_dividend = vec_q[w_lsb +: COMP_W];
    assign w_div_mag  = w_dividend[MAG_W-1:0];
    assign w_dz       = (scal_q[MAG_W-1:0] == '0);
    assign w_num      = {w_div_mag, {(FRAC_BITS + GUARD_BITS){1'b0}}};

    sv_div_core #(
        .ITERS (DIV_ITERS),
        .DEN_W (MAG_W)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .start_i    (w_core_start),
        .dividend_i (w_num),
        .divisor_i  (scal_q[MAG_W-1:0]),
        .busy_o     (w_core_busy),
        .last_o     (w_core_last),
        .quotient_o (w_quo)
    );

    assign w_unused_busy = w_core_busy;

    // ------------------------------------------------------------------
    // Result formatting for the component being stored
    // ------------------------------------------------------------------
`ifdef SV_DIV_ROUND_EN
    // Drop the guard bit and add it back in: round half-up. Done before the
    // saturation test so a value rounding up to 2^18 still saturates.
    assign w_q_full = {1'b0, w_quo[DIV_ITERS-1:1]}
                    + {{(DIV_ITERS-1){1'b0}}, w_quo[0]};
`else
    assign w_q_full = w_quo;
`endif

    assign w_sat = |w_q_full[DIV_ITERS-1:MAG_W];

    always_comb begin
        w_mag_res = w_q_full[MAG_W-1:0];
        if (w_dz) begin
            w_mag_res = (w_div_mag != '0) ? MAG_MAX : '0;
        end else if (w_sat) begin
            w_mag_res = MAG_MAX;
        end
    end

    // No negative zero: a zero magnitude always carries a positive sign.
    assign w_sign_res = (w_mag_res != '0) && (w_dividend[COMP_W-1] ^ scal_q[COMP_W-1]);
    assign w_comp_res = {w_sign_res, w_mag_res};

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            comp_q  <= '0;
            vec_q   <= '0;
            scal_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            comp_q  <= comp_d;
            vec_q   <= vec_d;
            scal_q  <= scal_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        comp_d       = comp_q;
        vec_d        = vec_q;
        scal_d       = scal_q;
        res_d        = res_q;
        w_core_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    vec_d   = bus.in_vector;
                    scal_d  = bus.in_scalar;
                    comp_d  = 2'd0;
                    res_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // A zero divisor leaves the core idle and passes through
                // ITER for a single cycle, giving 3 cycles per component.
                w_core_start = ~w_dz;
                state_d      = ITER;
            end
            ITER: begin
                if (w_dz || w_core_last) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                res_d[w_lsb +: COMP_W] = w_comp_res;
                if (comp_q < 2'd2) begin
                    comp_d  = comp_q + 2'd1;
                    state_d = SETUP;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: the result bus only shows completed vectors
    // ------------------------------------------------------------------
    assign bus.in_ready    = (state_q == IDLE) && !rst;
    assign bus.out_valid   = (state_q == DONE);
    assign bus.out_vector  = (state_q == DONE) ? res_q : '0;
    assign bus.div_by_zero = (state_q == DONE) && w_dz;

endmodule

`default_nettype wire

// File: tb/tb_signed_vector_scalar_divider.sv
// ============================================================================
//  Module      : tb_signed_vector_scalar_divider
//  Description : Self-checking bench for signed_vector_scalar_divider with a
//                plain-arithmetic reference model and randomized operands.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signed_vector_scalar_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef SV_DIV_ROUND_EN
    localparam int LAT = 93;
`else
    localparam int LAT = 90;
`endif

    signed_vector_scalar_divider_if bus();

    signed_vector_scalar_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: magnitudes as integers, quotient = a * 2^10 / b.
    function automatic logic [18:0] ref_comp(input logic [18:0] a, input logic [18:0] b);
        longint unsigned ma;
        longint unsigned mb;
        longint unsigned q;
        logic            s;
        ma = 64'(a[17:0]);
        mb = 64'(b[17:0]);
        if (mb == 64'd0) begin
            q = (ma == 64'd0) ? 64'd0 : 64'd262143;
        end else begin
`ifdef SV_DIV_ROUND_EN
            q = (ma * 64'd2048 + mb) / (64'd2 * mb);
`else
            q = (ma * 64'd1024) / mb;
`endif
            if (q > 64'd262143) q = 64'd262143;
        end
        s = (q != 64'd0) && (a[18] ^ b[18]);
        return {s, q[17:0]};
    endfunction

    task automatic run_op(input string tag, input logic [56:0] v, input logic [18:0] s,
                          input int hold, output logic [56:0] obs_v);
        logic [56:0] exp_v;
        logic        exp_dz;
        int          exp_lat;
        int          n;
        bit          got;
        exp_v   = {ref_comp(v[56:38], s), ref_comp(v[37:19], s), ref_comp(v[18:0], s)};
        exp_dz  = (s[17:0] == 18'd0);
        exp_lat = exp_dz ? 9 : LAT;
        obs_v   = '0;

        @(negedge clk);
        check({tag, ".idle_ready"}, 64'(bus.in_ready), 64'(1));
        bus.in_valid  = 1'b1;
        bus.in_vector = v;
        bus.in_scalar = s;
        @(posedge clk);
        #1;
        // Scramble the input bus: captured operands must not follow it.
        bus.in_vector = 57'({$urandom(), $urandom()});
        bus.in_scalar = 19'($urandom());
        bus.in_valid  = 1'b0;
        check({tag, ".busy_ready"}, 64'(bus.in_ready), 64'(0));

        got = 1'b0;
        for (n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            bus.in_valid = 1'($urandom_range(0, 1));
        end
        bus.in_valid = 1'b0;
        check({tag, ".latency"}, 64'(got ? n : 0), 64'(exp_lat));
        if (!got) return;

        obs_v = bus.out_vector;
        check({tag, ".vector"}, 64'(bus.out_vector), 64'(exp_v));
        check({tag, ".dbz"}, 64'(bus.div_by_zero), 64'(exp_dz));
        check({tag, ".done_ready"}, 64'(bus.in_ready), 64'(0));

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'(1));
            check({tag, ".hold_vector"}, 64'(bus.out_vector), 64'(exp_v));
            check({tag, ".hold_ready"}, 64'(bus.in_ready), 64'(0));
        end

        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".after_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, ".after_ready"}, 64'(bus.in_ready), 64'(1));
    endtask

    function automatic logic [18:0] rand_comp();
        logic [17:0] m;
        case ($urandom_range(0, 3))
            0:       m = 18'($urandom_range(0, 1023));
            1:       m = 18'd0;
            default: m = 18'($urandom());
        endcase
        return {1'($urandom()), m};
    endfunction

    function automatic logic [18:0] rand_scalar();
        logic [17:0] m;
        case ($urandom_range(0, 7))
            0:       m = 18'd0;
            1, 2:    m = 18'($urandom_range(1, 1023));
            default: m = 18'($urandom());
        endcase
        return {1'($urandom()), m};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [56:0] obs;
        logic [18:0] x2_3;

        bus.in_valid  = 1'b0;
        bus.in_vector = '0;
        bus.in_scalar = '0;
        bus.out_ready = 1'b0;

        #1;
        check("rst.in_ready", 64'(bus.in_ready), 64'(0));
        check("rst.out_valid", 64'(bus.out_valid), 64'(0));
        check("rst.out_vector", 64'(bus.out_vector), 64'(0));
        check("rst.dbz", 64'(bus.div_by_zero), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel.in_ready", 64'(bus.in_ready), 64'(1));

        run_op("tp1", {19'h00800, 19'h40400, 19'h00200}, 19'h00800, 5, obs);
        check("tp1.lit", 64'(obs), 64'({19'h00400, 19'h40200, 19'h00100}));

        run_op("tp2", {19'h32000, 19'h00000, 19'h00000}, 19'h00200, 0, obs);
        check("tp2.lit", 64'(obs[56:38]), 64'(19'h3FFFF));

        run_op("tp3", {19'h40400, 19'h00000, 19'h00000}, 19'h40800, 0, obs);
        check("tp3.lit", 64'(obs[56:38]), 64'(19'h00200));

        run_op("tp4", {19'h00400, 19'h00000, 19'h40400}, 19'h00000, 0, obs);
        check("tp4.lit", 64'(obs), 64'({19'h3FFFF, 19'h00000, 19'h7FFFF}));

`ifdef SV_DIV_ROUND_EN
        x2_3 = 19'h002AB;
`else
        x2_3 = 19'h002AA;
`endif
        run_op("tp5", {19'h00800, 19'h00000, 19'h00000}, 19'h00C00, 0, obs);
        check("tp5.lit", 64'(obs[56:38]), 64'(x2_3));

        // Reset in the middle of an operation
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_vector = {19'h00800, 19'h00800, 19'h00800};
        bus.in_scalar = 19'h00400;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst.in_ready", 64'(bus.in_ready), 64'(0));
        check("mid_rst.out_valid", 64'(bus.out_valid), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst.rel_ready", 64'(bus.in_ready), 64'(1));
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) break;
        end
        check("mid_rst.no_valid", 64'(bus.out_valid), 64'(0));
        run_op("post_rst", {19'h40C00, 19'h00100, 19'h00000}, 19'h00400, 1, obs);

        for (int k = 0; k < 24; k++) begin
            run_op($sformatf("rnd%0d", k),
                   {rand_comp(), rand_comp(), rand_comp()}, rand_scalar(),
                   int'($urandom_range(0, 2)), obs);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
